shift_add_multiplier: RTL and testbench

- Multi-cycle unsigned multiplier controller that computes one partial product per cycle with the shift-and-add method.
- Sequences a single shared Adder instance, so wide products need no combinational multiplier.
- Sits beside the ALU. The CPU control unit raises start and stalls on busy until done.

---
 rtl/shift_add_multiplier_pkg.sv | 15 +
 rtl/shift_add_multiplier_adder.sv | 16 +
 rtl/shift_add_multiplier.sv | 110 +++++++++++
 tb/tb_shift_add_multiplier.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   - State encoding for the controller FSM (IDLE / RUN / DONE).
//   - cw_of(): width of the step counter needed to count 0..n.
package shift_add_multiplier_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Counter must hold values up to n, hence n+1 distinct codes.
  function automatic int cw_of(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// Plain unsigned adder shared by the multiplier datapath.
// Ports:
//   a, b : size-bit unsigned operands
//   sum  : size-bit sum. The caller sizes the operands one bit wider than
//          the data so that the carry is kept and nothing is lost.
module adder #(
  parameter int size = 33
) (
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  output logic [size-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned shift-and-add multiplier.
// One partial product is added per clock through a single adder of width
// size+1, so the full 2*size product takes exactly size RUN cycles.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset (aborts any operation)
//   start   : request, sampled only in IDLE
//   a, b    : multiplicand / multiplier, captured when start is accepted
//   product : registered 2*size-bit result, updated only on completion
//   busy    : high while in RUN
//   done    : one-cycle pulse in the cycle after product is updated
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int size = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [size-1:0]   a,
  input  logic [size-1:0]   b,
  output logic [2*size-1:0] product,
  output logic              busy,
  output logic              done
);

  localparam int CW = cw_of(size);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [size-1:0] hi;
  logic [size-1:0] lo;
  logic [size-1:0] mcand;
  logic [CW-1:0]   count;
  logic [size:0]   add_a;
  logic [size:0]   add_b;
  logic [size:0]   sum;
  logic            last;

  // The current step is the final one when count reaches size-1.
  assign last  = (count == CW'(size - 1));

  // lo[0] is the multiplier bit for this step; it gates the multiplicand.
  assign add_a = {1'b0, hi};
  assign add_b = lo[0] ? {1'b0, mcand} : '0;

  adder #(
    .size(size + 1)
  ) u_adder (
    .a   (add_a),
    .b   (add_b),
    .sum (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath: {hi,lo} shifts right one bit per step, with the adder's carry
  // entering at the top of hi and sum[0] dropping into the top of lo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            lo    <= b;
            hi    <= '0;
            count <= '0;
          end
        end
        RUN: begin
          hi    <= sum[size:1];
          lo    <= {sum[0], lo[size-1:1]};
          count <= count + CW'(1);
          if (last) begin
            product <= {sum[size:1], sum[0], lo[size-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start32;
  logic [7:0]  a8, b8;
  logic [31:0] a32, b32;
  logic [15:0] product8;
  logic [63:0] product32;
  logic        busy8, done8, busy32, done32;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] last_prod8  = '0;
  logic [63:0] last_prod32 = '0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.size(8)) u_dut8 (
    .clk     (clk),
    .rst     (rst),
    .start   (start8),
    .a       (a8),
    .b       (b8),
    .product (product8),
    .busy    (busy8),
    .done    (done8)
  );

  shift_add_multiplier #(.size(32)) u_dut32 (
    .clk     (clk),
    .rst     (rst),
    .start   (start32),
    .a       (a32),
    .b       (b32),
    .product (product32),
    .busy    (busy32),
    .done    (done32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one multiplication on the chosen DUT and verify timing and result.
  task automatic issue(input bit wide, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp;
    int sz;
    int cyc;
    int busy_cnt;
    bit seen;
    logic o_busy, o_done;
    logic [63:0] o_prod;
    sz  = wide ? 32 : 8;
    exp = wide ? ({32'b0, a} * {32'b0, b}) : ({56'b0, a[7:0]} * {56'b0, b[7:0]});
    @(negedge clk);
    if (wide) begin start32 = 1'b1; a32 = a; b32 = b; end
    else      begin start8  = 1'b1; a8  = a[7:0]; b8 = b[7:0]; end
    @(posedge clk);
    @(negedge clk);
    // Drop start and scramble operands: must not affect the accepted job.
    if (wide) begin start32 = 1'b0; a32 = $urandom; b32 = $urandom; end
    else      begin start8  = 1'b0; a8  = 8'($urandom); b8 = 8'($urandom); end
    o_prod = wide ? product32 : {48'b0, product8};
    check({tag, "_hold_run"}, o_prod, wide ? last_prod32 : last_prod8);
    cyc = 1; busy_cnt = 0; seen = 1'b0;
    o_busy = 1'b0;
    while (cyc <= sz + 10) begin
      o_busy = wide ? busy32 : busy8;
      o_done = wide ? done32 : done8;
      if (o_done) begin seen = 1'b1; break; end
      if (o_busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      o_prod = wide ? product32 : {48'b0, product8};
      check({tag, "_latency"}, 64'(cyc), 64'(sz + 1));
      check({tag, "_busycycles"}, 64'(busy_cnt), 64'(sz));
      check({tag, "_busy_at_done"}, {63'b0, o_busy}, 64'd0);
      check({tag, "_product"}, o_prod, exp);
      if (wide) last_prod32 = exp; else last_prod8 = exp;
      @(negedge clk);
      check({tag, "_done_single"}, {63'b0, wide ? done32 : done8}, 64'd0);
    end
  endtask

  initial begin
    int n_done;
    rst = 1'b1; start8 = 1'b0; start32 = 1'b0;
    a8 = '0; b8 = '0; a32 = '0; b32 = '0;
    @(negedge clk); @(negedge clk);
    check("rst_prod8",  {48'b0, product8}, 64'd0);
    check("rst_busy8",  {63'b0, busy8}, 64'd0);
    check("rst_done8",  {63'b0, done8}, 64'd0);
    check("rst_prod32", product32, 64'd0);
    check("rst_busy32", {63'b0, busy32}, 64'd0);
    check("rst_done32", {63'b0, done32}, 64'd0);
    rst = 1'b0;

    issue(1'b0, 32'd13, 32'd11, "m13x11");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_hold_prod", {48'b0, product8}, 64'd143);
      check("idle_hold_done", {63'b0, done8}, 64'd0);
    end

    issue(1'b0, 32'd255, 32'd255, "m255x255");
    issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "w_max");
    issue(1'b1, 32'd0, 32'h1234_5678, "w_zero");
    issue(1'b0, 32'd0, 32'd0, "zero8");

    for (int i = 0; i < 8; i++) issue(1'b0, $urandom, $urandom, "rand8");
    for (int i = 0; i < 4; i++) issue(1'b1, $urandom, $urandom, "rand32");

    // start held high through RUN and DONE: only one job, then next in IDLE.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd3; b8 = 8'd5;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'd7; b8 = 8'd7;
    n_done = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (cyc == 11) start8 = 1'b0;
      if (done8) begin
        n_done++;
        if (n_done == 1) begin
          check("hold_start_cyc1", 64'(cyc), 64'd9);
          check("hold_start_p1", {48'b0, product8}, 64'd15);
        end else if (n_done == 2) begin
          check("hold_start_cyc2", 64'(cyc), 64'd19);
          check("hold_start_p2", {48'b0, product8}, 64'd49);
        end
      end
      @(negedge clk);
    end
    check("hold_start_ndone", 64'(n_done), 64'd2);
    last_prod8 = 64'd49;

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd200;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_prod", {48'b0, product8}, 64'd0);
    check("abort_busy", {63'b0, busy8}, 64'd0);
    check("abort_done", {63'b0, done8}, 64'd0);
    n_done = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (cyc == 2) rst = 1'b0;
      if (done8) n_done++;
    end
    check("abort_no_done", 64'(n_done), 64'd0);
    check("abort_prod_after", {48'b0, product8}, 64'd0);
    last_prod8 = '0; last_prod32 = '0;
    issue(1'b0, 32'd6, 32'd9, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
